axis_packet_accumulator: RTL

//  Sits directly downstream of axis_packetizer. Consumes tlast-delimited AXI4-Stream packets and sums every

---
 rtl/axis_packet_accumulator_pkg.sv | 24 ++
 rtl/axis_packet_accumulator_add.sv | 33 +++
 rtl/axis_packet_accumulator.sv | 84 ++++++++
 3 files changed

// File: rtl/axis_packet_accumulator_pkg.sv
// Shared types and helpers for axis_packet_accumulator: output-side FSM states and sample extension.
package axis_packet_accumulator_pkg;

  typedef enum logic {
    ST_ACC,
    ST_HOLD
  } state_t;

  // Widest sample/accumulator the extension helper can carry.
  localparam int EXT_MAX_W = 128;

  // Extends a width-bit value held in the low bits of data to EXT_MAX_W bits.
  function automatic logic [EXT_MAX_W-1:0] ext(input logic [EXT_MAX_W-1:0] data,
                                               input int                   width,
                                               input bit                   is_signed);
    logic [EXT_MAX_W-1:0] res;
    res = data;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i >= width) res[i] = is_signed & data[width-1];
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_packet_accumulator_add.sv
// Combinational ACC_WIDTH adder; saturates to the signed/unsigned range when
// AXIS_PACKET_ACCUMULATOR_SAT_EN is defined, otherwise wraps.
module axis_packet_accumulator_add #(
  parameter int ACC_WIDTH = 48,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum
);

`ifdef AXIS_PACKET_ACCUMULATOR_SAT_EN
  localparam int MSB = ACC_WIDTH - 1;

  logic [ACC_WIDTH:0] wide;

  always_comb begin
    wide = {1'b0, a} + {1'b0, b};
    sum  = wide[ACC_WIDTH-1:0];
    if (IS_SIGNED) begin
      // Signed overflow: operands agree in sign but the result does not.
      if ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])) begin
        sum = a[MSB] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end else if (wide[ACC_WIDTH]) begin
      sum = '1;
    end
  end
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/axis_packet_accumulator.sv
// Sums each tlast-delimited AXI4-Stream packet into one result beat, counts packets and flags
// length mismatches. Define AXIS_PACKET_ACCUMULATOR_SAT_EN for saturating accumulation.
module axis_packet_accumulator
  import axis_packet_accumulator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ACC_WIDTH        = 48,
  parameter int CNTR_WIDTH       = 32,
  parameter int TDATA_SIGNED     = 0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [ACC_WIDTH-1:0]        m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic [CNTR_WIDTH-1:0]       sts_data,
  output logic                        sts_error
);

  state_t                state, state_next;
  logic [ACC_WIDTH-1:0]  acc;
  logic [ACC_WIDTH-1:0]  sample_ext;
  logic [ACC_WIDTH-1:0]  sum;
  logic [CNTR_WIDTH-1:0] beat_cnt;
  logic                  in_fire;
  logic                  last_fire;

  // A result is held exactly while in ST_HOLD, so tvalid comes straight from the state register.
  assign m_axis_tvalid = (state == ST_HOLD);
  assign s_axis_tready = !(m_axis_tvalid && !m_axis_tready);
  assign in_fire       = s_axis_tvalid && s_axis_tready;
  assign last_fire     = in_fire && s_axis_tlast;

  assign sample_ext = ACC_WIDTH'(ext(EXT_MAX_W'(s_axis_tdata), AXIS_TDATA_WIDTH, TDATA_SIGNED != 0));

  axis_packet_accumulator_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .IS_SIGNED (TDATA_SIGNED != 0)
  ) u_add (
    .a   (acc),
    .b   (sample_ext),
    .sum (sum)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_ACC:  if (last_fire) state_next = ST_HOLD;
      ST_HOLD: if (!last_fire && m_axis_tready) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_ACC;
      acc          <= '0;
      beat_cnt     <= '0;
      m_axis_tdata <= '0;
      sts_data     <= '0;
      sts_error    <= 1'b0;
    end else begin
      state <= state_next;
      if (last_fire) begin
        m_axis_tdata <= sum;
        acc          <= '0;
        beat_cnt     <= '0;
        sts_data     <= sts_data + CNTR_WIDTH'(1);
        if (beat_cnt != cfg_data) sts_error <= 1'b1;
      end else if (in_fire) begin
        acc <= sum;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + CNTR_WIDTH'(1);
      end
    end
  end

endmodule
